exec_mask_rf: RTL and testbench

Parametrised per-wavefront EXEC/VCC/M0/SCC state file for the compute unit, replacing the fixed 4-SIMD/4-SIMF exec block. VALU unit count, wavefront count and lane width are configurable. SALU exec writes support AND/OR/ANDN2 read-modify-write modes. The block exports a registered per-wavefront EXEC-zero vector for branch logic and a sticky write-conflict flag. It sits between fetch/SALU/VALU writers and the issue, LSU, SALU and VALU readers.

---
 rtl/exec_pkg.sv | 19 +
 rtl/exec_rd_port.sv | 52 +++++
 rtl/exec_mask_rf.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_exec_mask_rf.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared encodings for the per-wavefront EXEC/VCC/M0/SCC state
//                file: SALU exec write modes and the M0 register width.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    // SALU exec write modes (read-modify-write against the stored EXEC)
    localparam logic [1:0] EXEC_REPLACE = 2'b00;  // new = value
    localparam logic [1:0] EXEC_AND     = 2'b01;  // new = old & value
    localparam logic [1:0] EXEC_OR      = 2'b10;  // new = old | value
    localparam logic [1:0] EXEC_ANDN2   = 2'b11;  // new = old & ~value

    localparam int M0_W = 32;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_rd_port.sv
`default_nettype none
// ============================================================================
//  Module      : exec_rd_port
//  Description : Registered read port with write-first bypass. The caller
//                supplies the post-write (next-state) record of every slot,
//                so a read issued in the same cycle as a write returns the
//                written value one cycle later.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                rd_en         - capture a new read this cycle
//                rd_wfid       - slot to read (out-of-range returns 0)
//                rd_nxt        - next-state record of every slot
//                rd_data       - registered read data, held while !rd_en
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_rd_port #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6,
    parameter int DW     = 161
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic [WFID_W-1:0]          rd_wfid,
    input  logic [NUM_WF-1:0][DW-1:0]  rd_nxt,
    output logic [DW-1:0]              rd_data
);

    // One extra bit so NUM_WF == 2**WFID_W still compares correctly
    localparam logic [WFID_W:0] c_WF_LIMIT = (WFID_W+1)'(NUM_WF);

    logic [DW-1:0] w_data_d;
    logic [DW-1:0] r_data_q;

    always_comb begin
        w_data_d = r_data_q;
        if (rd_en) begin
            w_data_d = ({1'b0, rd_wfid} < c_WF_LIMIT) ? rd_nxt[rd_wfid] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= w_data_d;
        end
    end

    assign rd_data = r_data_q;

endmodule : exec_rd_port
`default_nettype wire

// File: rtl/exec_mask_rf.sv
`default_nettype none
// ============================================================================
//  Module      : exec_mask_rf
//  Description : Per-wavefront EXEC/VCC/M0/SCC state file. Writers: fetch
//                init, SALU (with AND/OR/ANDN2 exec RMW), granted VALU VCC.
//                Readers: SALU, VALU (lowest requesting unit), LSU (always).
//                Exports registered EXEC-zero vector, commit notices and a
//                sticky SALU/VALU VCC write-conflict flag.
//  Ports       : fetch_init_*  - slot initialisation (EXEC set, rest cleared)
//                salu_wr_*     - SALU field writes, salu_rd_* - SALU read
//                valu_vcc_*    - per-unit VCC writes qualified by rfa_select_fu
//                valu_rd_*     - per-unit read requests / shared read data
//                lsu_*         - LSU read, captured every cycle
//                exec_zero     - bit w set when EXEC of slot w is all zero
//                issue_*       - one-cycle commit notices with committed wfid
//                wr_conflict_err - sticky until reset
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_mask_rf
    import exec_pkg::*;
#(
    parameter int NUM_WF   = 40,
    parameter int WFID_W   = 6,
    parameter int LANES    = 64,
    parameter int NUM_VALU = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_init_wf_en,
    input  logic [WFID_W-1:0]            fetch_init_wf_id,
    input  logic [LANES-1:0]             fetch_init_value,
    input  logic                         salu_wr_exec_en,
    input  logic                         salu_wr_vcc_en,
    input  logic                         salu_wr_m0_en,
    input  logic                         salu_wr_scc_en,
    input  logic [1:0]                   salu_wr_exec_mode,
    input  logic [WFID_W-1:0]            salu_wr_wfid,
    input  logic [LANES-1:0]             salu_wr_exec_value,
    input  logic [LANES-1:0]             salu_wr_vcc_value,
    input  logic [31:0]                  salu_wr_m0_value,
    input  logic                         salu_wr_scc_value,
    input  logic                         salu_rd_en,
    input  logic [WFID_W-1:0]            salu_rd_wfid,
    input  logic [WFID_W-1:0]            lsu_rd_wfid,
    input  logic [NUM_VALU-1:0]          valu_rd_en,
    input  logic [NUM_VALU*WFID_W-1:0]   valu_rd_wfid,
    input  logic [NUM_VALU-1:0]          valu_vcc_wr_en,
    input  logic [NUM_VALU*WFID_W-1:0]   valu_vcc_wr_wfid,
    input  logic [NUM_VALU*LANES-1:0]    valu_vcc_value,
    input  logic [NUM_VALU-1:0]          rfa_select_fu,
    output logic [LANES-1:0]             salu_rd_exec_value,
    output logic [LANES-1:0]             salu_rd_vcc_value,
    output logic [LANES-1:0]             valu_rd_exec_value,
    output logic [LANES-1:0]             valu_rd_vcc_value,
    output logic [LANES-1:0]             lsu_exec_value,
    output logic [31:0]                  salu_rd_m0_value,
    output logic [31:0]                  valu_rd_m0_value,
    output logic [31:0]                  lsu_rd_m0_value,
    output logic                         salu_rd_scc_value,
    output logic                         valu_rd_scc_value,
    output logic [NUM_WF-1:0]            exec_zero,
    output logic                         issue_salu_wr_exec_en,
    output logic                         issue_salu_wr_vcc_en,
    output logic                         issue_salu_wr_m0_en,
    output logic                         issue_salu_wr_scc_en,
    output logic [WFID_W-1:0]            issue_salu_wr_vcc_wfid,
    output logic                         issue_valu_wr_vcc_en,
    output logic [WFID_W-1:0]            issue_valu_wr_vcc_wfid,
    output logic                         wr_conflict_err
);

    localparam logic [WFID_W:0] c_WF_LIMIT = (WFID_W+1)'(NUM_WF);
    // Read record layout: {exec, vcc, m0, scc}; LSU only needs {exec, m0}
    localparam int REC_W = 2*LANES + M0_W + 1;
    localparam int LSU_W = LANES + M0_W;

    // ------------------------------------------------------------------
    // State storage
    // ------------------------------------------------------------------
    logic [NUM_WF-1:0][LANES-1:0] r_exec_q, w_exec_d;
    logic [NUM_WF-1:0][LANES-1:0] r_vcc_q,  w_vcc_d;
    logic [NUM_WF-1:0][M0_W-1:0]  r_m0_q,   w_m0_d;
    logic [NUM_WF-1:0]            r_scc_q,  w_scc_d;
    logic [NUM_WF-1:0]            r_exec_zero_q, w_exec_zero_d;

    logic                r_iss_exec_q, w_iss_exec_d;
    logic                r_iss_vcc_q,  w_iss_vcc_d;
    logic                r_iss_m0_q,   w_iss_m0_d;
    logic                r_iss_scc_q,  w_iss_scc_d;
    logic [WFID_W-1:0]   r_iss_salu_wfid_q, w_iss_salu_wfid_d;
    logic                r_iss_valu_q, w_iss_valu_d;
    logic [WFID_W-1:0]   r_iss_valu_wfid_q, w_iss_valu_wfid_d;
    logic                r_conflict_q, w_conflict_d;

    // ------------------------------------------------------------------
    // VALU write arbitration: only granted units commit; lowest wins if
    // the grant is ever not one-hot.
    // ------------------------------------------------------------------
    logic                w_valu_vld;
    logic [WFID_W-1:0]   w_valu_wfid;
    logic [LANES-1:0]    w_valu_val;

    always_comb begin
        w_valu_vld  = 1'b0;
        w_valu_wfid = '0;
        w_valu_val  = '0;
        for (int i = NUM_VALU-1; i >= 0; i--) begin
            if (valu_vcc_wr_en[i] && rfa_select_fu[i]) begin
                w_valu_vld  = 1'b1;
                w_valu_wfid = valu_vcc_wr_wfid[i*WFID_W +: WFID_W];
                w_valu_val  = valu_vcc_value[i*LANES +: LANES];
            end
        end
    end

    logic w_salu_ok, w_valu_ok, w_salu_any;
    assign w_salu_ok  = ({1'b0, salu_wr_wfid} < c_WF_LIMIT);
    assign w_valu_ok  = ({1'b0, w_valu_wfid} < c_WF_LIMIT);
    assign w_salu_any = salu_wr_exec_en | salu_wr_vcc_en | salu_wr_m0_en | salu_wr_scc_en;

    // ------------------------------------------------------------------
    // Next-state: writers applied lowest priority first so later
    // assignments win (VALU < SALU < fetch init). Out-of-range wfids
    // never match a slot index and fall out naturally.
    // ------------------------------------------------------------------
    always_comb begin
        w_exec_d = r_exec_q;
        w_vcc_d  = r_vcc_q;
        w_m0_d   = r_m0_q;
        w_scc_d  = r_scc_q;
        for (int w = 0; w < NUM_WF; w++) begin
            if (w_valu_vld && (w_valu_wfid == WFID_W'(w))) begin
                w_vcc_d[w] = w_valu_val;
            end
            if (salu_wr_wfid == WFID_W'(w)) begin
                if (salu_wr_exec_en) begin
                    case (salu_wr_exec_mode)
                        EXEC_AND:   w_exec_d[w] = r_exec_q[w] & salu_wr_exec_value;
                        EXEC_OR:    w_exec_d[w] = r_exec_q[w] | salu_wr_exec_value;
                        EXEC_ANDN2: w_exec_d[w] = r_exec_q[w] & ~salu_wr_exec_value;
                        default:    w_exec_d[w] = salu_wr_exec_value;
                    endcase
                end
                if (salu_wr_vcc_en) w_vcc_d[w] = salu_wr_vcc_value;
                if (salu_wr_m0_en)  w_m0_d[w]  = salu_wr_m0_value;
                if (salu_wr_scc_en) w_scc_d[w] = salu_wr_scc_value;
            end
            if (fetch_init_wf_en && (fetch_init_wf_id == WFID_W'(w))) begin
                w_exec_d[w] = fetch_init_value;
                w_vcc_d[w]  = '0;
                w_m0_d[w]   = '0;
                w_scc_d[w]  = 1'b0;
            end
        end
    end

    // Commit notices and sticky conflict flag
    always_comb begin
        w_iss_exec_d      = salu_wr_exec_en & w_salu_ok;
        w_iss_vcc_d       = salu_wr_vcc_en  & w_salu_ok;
        w_iss_m0_d        = salu_wr_m0_en   & w_salu_ok;
        w_iss_scc_d       = salu_wr_scc_en  & w_salu_ok;
        w_iss_salu_wfid_d = (w_salu_any && w_salu_ok) ? salu_wr_wfid : '0;
        w_iss_valu_d      = w_valu_vld & w_valu_ok;
        w_iss_valu_wfid_d = (w_valu_vld && w_valu_ok) ? w_valu_wfid : '0;
        w_conflict_d      = r_conflict_q |
                            (w_iss_vcc_d && w_iss_valu_d && (salu_wr_wfid == w_valu_wfid));
    end

    // ------------------------------------------------------------------
    // Read records and EXEC-zero, all from post-write state (bypass)
    // ------------------------------------------------------------------
    logic [NUM_WF-1:0][REC_W-1:0] w_rec_nxt;
    logic [NUM_WF-1:0][LSU_W-1:0] w_lsu_nxt;

    for (genvar g = 0; g < NUM_WF; g++) begin : g_rec
        assign w_rec_nxt[g]     = {w_exec_d[g], w_vcc_d[g], w_m0_d[g], w_scc_d[g]};
        assign w_lsu_nxt[g]     = {w_exec_d[g], w_m0_d[g]};
        assign w_exec_zero_d[g] = ~|w_exec_d[g];
    end

    // VALU read port serves the lowest-index requesting unit
    logic [WFID_W-1:0] w_valu_rd_wfid;
    always_comb begin
        w_valu_rd_wfid = '0;
        for (int i = NUM_VALU-1; i >= 0; i--) begin
            if (valu_rd_en[i]) w_valu_rd_wfid = valu_rd_wfid[i*WFID_W +: WFID_W];
        end
    end

    logic [REC_W-1:0] w_salu_rec, w_valu_rec;
    logic [LSU_W-1:0] w_lsu_rec;

    exec_rd_port #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .DW(REC_W)) u_salu_rd (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (salu_rd_en),
        .rd_wfid (salu_rd_wfid),
        .rd_nxt  (w_rec_nxt),
        .rd_data (w_salu_rec)
    );

    exec_rd_port #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .DW(REC_W)) u_valu_rd (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (|valu_rd_en),
        .rd_wfid (w_valu_rd_wfid),
        .rd_nxt  (w_rec_nxt),
        .rd_data (w_valu_rec)
    );

    exec_rd_port #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .DW(LSU_W)) u_lsu_rd (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (1'b1),
        .rd_wfid (lsu_rd_wfid),
        .rd_nxt  (w_lsu_nxt),
        .rd_data (w_lsu_rec)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exec_q          <= '0;
            r_vcc_q           <= '0;
            r_m0_q            <= '0;
            r_scc_q           <= '0;
            r_exec_zero_q     <= '1;
            r_iss_exec_q      <= 1'b0;
            r_iss_vcc_q       <= 1'b0;
            r_iss_m0_q        <= 1'b0;
            r_iss_scc_q       <= 1'b0;
            r_iss_salu_wfid_q <= '0;
            r_iss_valu_q      <= 1'b0;
            r_iss_valu_wfid_q <= '0;
            r_conflict_q      <= 1'b0;
        end else begin
            r_exec_q          <= w_exec_d;
            r_vcc_q           <= w_vcc_d;
            r_m0_q            <= w_m0_d;
            r_scc_q           <= w_scc_d;
            r_exec_zero_q     <= w_exec_zero_d;
            r_iss_exec_q      <= w_iss_exec_d;
            r_iss_vcc_q       <= w_iss_vcc_d;
            r_iss_m0_q        <= w_iss_m0_d;
            r_iss_scc_q       <= w_iss_scc_d;
            r_iss_salu_wfid_q <= w_iss_salu_wfid_d;
            r_iss_valu_q      <= w_iss_valu_d;
            r_iss_valu_wfid_q <= w_iss_valu_wfid_d;
            r_conflict_q      <= w_conflict_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign salu_rd_exec_value = w_salu_rec[REC_W-1 -: LANES];
    assign salu_rd_vcc_value  = w_salu_rec[M0_W+1 +: LANES];
    assign salu_rd_m0_value   = w_salu_rec[1 +: M0_W];
    assign salu_rd_scc_value  = w_salu_rec[0];
    assign valu_rd_exec_value = w_valu_rec[REC_W-1 -: LANES];
    assign valu_rd_vcc_value  = w_valu_rec[M0_W+1 +: LANES];
    assign valu_rd_m0_value   = w_valu_rec[1 +: M0_W];
    assign valu_rd_scc_value  = w_valu_rec[0];
    assign lsu_exec_value     = w_lsu_rec[LSU_W-1 -: LANES];
    assign lsu_rd_m0_value    = w_lsu_rec[M0_W-1:0];

    assign exec_zero              = r_exec_zero_q;
    assign issue_salu_wr_exec_en  = r_iss_exec_q;
    assign issue_salu_wr_vcc_en   = r_iss_vcc_q;
    assign issue_salu_wr_m0_en    = r_iss_m0_q;
    assign issue_salu_wr_scc_en   = r_iss_scc_q;
    assign issue_salu_wr_vcc_wfid = r_iss_salu_wfid_q;
    assign issue_valu_wr_vcc_en   = r_iss_valu_q;
    assign issue_valu_wr_vcc_wfid = r_iss_valu_wfid_q;
    assign wr_conflict_err        = r_conflict_q;

endmodule : exec_mask_rf
`default_nettype wire

// File: tb/tb_exec_mask_rf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_mask_rf
//  Description : Self-checking bench for exec_mask_rf: directed stimulus, a
//                per-cycle reference model of the state file, and literal
//                expectations from hand calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_mask_rf;

    localparam int NW = 40;
    localparam int WW = 6;
    localparam int LN = 64;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst;
    logic fetch_init_wf_en;
    logic [WW-1:0] fetch_init_wf_id;
    logic [LN-1:0] fetch_init_value;
    logic salu_wr_exec_en, salu_wr_vcc_en, salu_wr_m0_en, salu_wr_scc_en;
    logic [1:0] salu_wr_exec_mode;
    logic [WW-1:0] salu_wr_wfid;
    logic [LN-1:0] salu_wr_exec_value, salu_wr_vcc_value;
    logic [31:0] salu_wr_m0_value;
    logic salu_wr_scc_value;
    logic salu_rd_en;
    logic [WW-1:0] salu_rd_wfid, lsu_rd_wfid;
    logic [NV-1:0] valu_rd_en, valu_vcc_wr_en, rfa_select_fu;
    logic [NV*WW-1:0] valu_rd_wfid, valu_vcc_wr_wfid;
    logic [NV*LN-1:0] valu_vcc_value;
    logic [LN-1:0] salu_rd_exec_value, salu_rd_vcc_value, valu_rd_exec_value, valu_rd_vcc_value, lsu_exec_value;
    logic [31:0] salu_rd_m0_value, valu_rd_m0_value, lsu_rd_m0_value;
    logic salu_rd_scc_value, valu_rd_scc_value;
    logic [NW-1:0] exec_zero;
    logic issue_salu_wr_exec_en, issue_salu_wr_vcc_en, issue_salu_wr_m0_en, issue_salu_wr_scc_en;
    logic [WW-1:0] issue_salu_wr_vcc_wfid;
    logic issue_valu_wr_vcc_en;
    logic [WW-1:0] issue_valu_wr_vcc_wfid;
    logic wr_conflict_err;

    exec_mask_rf #(.NUM_WF(NW), .WFID_W(WW), .LANES(LN), .NUM_VALU(NV)) dut (
        .clk(clk), .rst(rst),
        .fetch_init_wf_en(fetch_init_wf_en), .fetch_init_wf_id(fetch_init_wf_id),
        .fetch_init_value(fetch_init_value),
        .salu_wr_exec_en(salu_wr_exec_en), .salu_wr_vcc_en(salu_wr_vcc_en),
        .salu_wr_m0_en(salu_wr_m0_en), .salu_wr_scc_en(salu_wr_scc_en),
        .salu_wr_exec_mode(salu_wr_exec_mode), .salu_wr_wfid(salu_wr_wfid),
        .salu_wr_exec_value(salu_wr_exec_value), .salu_wr_vcc_value(salu_wr_vcc_value),
        .salu_wr_m0_value(salu_wr_m0_value), .salu_wr_scc_value(salu_wr_scc_value),
        .salu_rd_en(salu_rd_en), .salu_rd_wfid(salu_rd_wfid), .lsu_rd_wfid(lsu_rd_wfid),
        .valu_rd_en(valu_rd_en), .valu_rd_wfid(valu_rd_wfid),
        .valu_vcc_wr_en(valu_vcc_wr_en), .valu_vcc_wr_wfid(valu_vcc_wr_wfid),
        .valu_vcc_value(valu_vcc_value), .rfa_select_fu(rfa_select_fu),
        .salu_rd_exec_value(salu_rd_exec_value), .salu_rd_vcc_value(salu_rd_vcc_value),
        .valu_rd_exec_value(valu_rd_exec_value), .valu_rd_vcc_value(valu_rd_vcc_value),
        .lsu_exec_value(lsu_exec_value),
        .salu_rd_m0_value(salu_rd_m0_value), .valu_rd_m0_value(valu_rd_m0_value),
        .lsu_rd_m0_value(lsu_rd_m0_value),
        .salu_rd_scc_value(salu_rd_scc_value), .valu_rd_scc_value(valu_rd_scc_value),
        .exec_zero(exec_zero),
        .issue_salu_wr_exec_en(issue_salu_wr_exec_en), .issue_salu_wr_vcc_en(issue_salu_wr_vcc_en),
        .issue_salu_wr_m0_en(issue_salu_wr_m0_en), .issue_salu_wr_scc_en(issue_salu_wr_scc_en),
        .issue_salu_wr_vcc_wfid(issue_salu_wr_vcc_wfid),
        .issue_valu_wr_vcc_en(issue_valu_wr_vcc_en), .issue_valu_wr_vcc_wfid(issue_valu_wr_vcc_wfid),
        .wr_conflict_err(wr_conflict_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: architectural state plus expected outputs
    // ------------------------------------------------------------------
    logic [LN-1:0] m_exec [NW];
    logic [LN-1:0] m_vcc  [NW];
    logic [31:0]   m_m0   [NW];
    logic          m_scc  [NW];
    logic [LN-1:0] e_s_exec, e_s_vcc, e_v_exec, e_v_vcc, e_l_exec;
    logic [31:0]   e_s_m0, e_v_m0, e_l_m0;
    logic          e_s_scc, e_v_scc;
    logic [NW-1:0] e_zero;
    logic          e_is_exec, e_is_vcc, e_is_m0, e_is_scc, e_iv, e_conf;
    logic [WW-1:0] e_is_wfid, e_iv_wfid;

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_exec[w] = '0; m_vcc[w] = '0; m_m0[w] = '0; m_scc[w] = 1'b0;
        end
        e_s_exec = '0; e_s_vcc = '0; e_s_m0 = '0; e_s_scc = 1'b0;
        e_v_exec = '0; e_v_vcc = '0; e_v_m0 = '0; e_v_scc = 1'b0;
        e_l_exec = '0; e_l_m0 = '0;
        e_zero = '1;
        e_is_exec = 0; e_is_vcc = 0; e_is_m0 = 0; e_is_scc = 0; e_is_wfid = '0;
        e_iv = 0; e_iv_wfid = '0; e_conf = 0;
    endtask

    task automatic model_step();
        int g, vr, s, v, f;
        bit valu_commit;
        g = -1;
        for (int i = 0; i < NV; i++)
            if (g < 0 && valu_vcc_wr_en[i] && rfa_select_fu[i]) g = i;
        s = int'(salu_wr_wfid);
        f = int'(fetch_init_wf_id);
        v = (g >= 0) ? int'(valu_vcc_wr_wfid[g*WW +: WW]) : 0;
        valu_commit = (g >= 0) && (v < NW);
        // Writes in ascending priority
        if (valu_commit) m_vcc[v] = valu_vcc_value[g*LN +: LN];
        if (s < NW) begin
            if (salu_wr_exec_en) begin
                case (salu_wr_exec_mode)
                    2'b00: m_exec[s] = salu_wr_exec_value;
                    2'b01: m_exec[s] = m_exec[s] & salu_wr_exec_value;
                    2'b10: m_exec[s] = m_exec[s] | salu_wr_exec_value;
                    default: m_exec[s] = m_exec[s] & ~salu_wr_exec_value;
                endcase
            end
            if (salu_wr_vcc_en) m_vcc[s] = salu_wr_vcc_value;
            if (salu_wr_m0_en)  m_m0[s]  = salu_wr_m0_value;
            if (salu_wr_scc_en) m_scc[s] = salu_wr_scc_value;
        end
        if (fetch_init_wf_en && f < NW) begin
            m_exec[f] = fetch_init_value; m_vcc[f] = '0; m_m0[f] = '0; m_scc[f] = 1'b0;
        end
        // Notices and conflict
        e_is_exec = salu_wr_exec_en && s < NW;
        e_is_vcc  = salu_wr_vcc_en  && s < NW;
        e_is_m0   = salu_wr_m0_en   && s < NW;
        e_is_scc  = salu_wr_scc_en  && s < NW;
        e_is_wfid = (s < NW && (salu_wr_exec_en || salu_wr_vcc_en || salu_wr_m0_en || salu_wr_scc_en))
                    ? salu_wr_wfid : '0;
        e_iv      = valu_commit;
        e_iv_wfid = valu_commit ? WW'(v) : '0;
        if (e_is_vcc && valu_commit && s == v) e_conf = 1'b1;
        // Reads see post-write state
        if (salu_rd_en) begin
            if (int'(salu_rd_wfid) < NW) begin
                e_s_exec = m_exec[salu_rd_wfid]; e_s_vcc = m_vcc[salu_rd_wfid];
                e_s_m0 = m_m0[salu_rd_wfid]; e_s_scc = m_scc[salu_rd_wfid];
            end else begin
                e_s_exec = '0; e_s_vcc = '0; e_s_m0 = '0; e_s_scc = 1'b0;
            end
        end
        vr = -1;
        for (int i = 0; i < NV; i++)
            if (vr < 0 && valu_rd_en[i]) vr = int'(valu_rd_wfid[i*WW +: WW]);
        if (valu_rd_en != '0) begin
            if (vr < NW) begin
                e_v_exec = m_exec[vr]; e_v_vcc = m_vcc[vr]; e_v_m0 = m_m0[vr]; e_v_scc = m_scc[vr];
            end else begin
                e_v_exec = '0; e_v_vcc = '0; e_v_m0 = '0; e_v_scc = 1'b0;
            end
        end
        if (int'(lsu_rd_wfid) < NW) begin
            e_l_exec = m_exec[lsu_rd_wfid]; e_l_m0 = m_m0[lsu_rd_wfid];
        end else begin
            e_l_exec = '0; e_l_m0 = '0;
        end
        for (int w = 0; w < NW; w++) e_zero[w] = (m_exec[w] == '0);
    endtask

    task automatic compare_all();
        chk("salu_exec", salu_rd_exec_value, e_s_exec);
        chk("salu_vcc",  salu_rd_vcc_value,  e_s_vcc);
        chk("salu_m0",   salu_rd_m0_value,   e_s_m0);
        chk("salu_scc",  salu_rd_scc_value,  e_s_scc);
        chk("valu_exec", valu_rd_exec_value, e_v_exec);
        chk("valu_vcc",  valu_rd_vcc_value,  e_v_vcc);
        chk("valu_m0",   valu_rd_m0_value,   e_v_m0);
        chk("valu_scc",  valu_rd_scc_value,  e_v_scc);
        chk("lsu_exec",  lsu_exec_value,     e_l_exec);
        chk("lsu_m0",    lsu_rd_m0_value,    e_l_m0);
        chk("exec_zero", exec_zero,          e_zero);
        chk("iss_exec",  issue_salu_wr_exec_en, e_is_exec);
        chk("iss_vcc",   issue_salu_wr_vcc_en,  e_is_vcc);
        chk("iss_m0",    issue_salu_wr_m0_en,   e_is_m0);
        chk("iss_scc",   issue_salu_wr_scc_en,  e_is_scc);
        chk("iss_swfid", issue_salu_wr_vcc_wfid, e_is_wfid);
        chk("iss_valu",  issue_valu_wr_vcc_en,  e_iv);
        chk("iss_vwfid", issue_valu_wr_vcc_wfid, e_iv_wfid);
        chk("conflict",  wr_conflict_err,       e_conf);
    endtask

    // Model advances on each edge, then DUT is compared 2 time units later
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #2;
            compare_all();
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        fetch_init_wf_en = 0; fetch_init_wf_id = '0; fetch_init_value = '0;
        salu_wr_exec_en = 0; salu_wr_vcc_en = 0; salu_wr_m0_en = 0; salu_wr_scc_en = 0;
        salu_wr_exec_mode = 2'b00; salu_wr_wfid = '0;
        salu_wr_exec_value = '0; salu_wr_vcc_value = '0; salu_wr_m0_value = '0; salu_wr_scc_value = 0;
        salu_rd_en = 0; salu_rd_wfid = '0;
        valu_rd_en = '0; valu_rd_wfid = '0;
        valu_vcc_wr_en = '0; valu_vcc_wr_wfid = '0; valu_vcc_value = '0; rfa_select_fu = '0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic salu_exec(input logic [1:0] mode, input logic [LN-1:0] val);
        @(negedge clk);
        idle();
        salu_wr_exec_en = 1; salu_wr_exec_mode = mode; salu_wr_wfid = 6'd2; salu_wr_exec_value = val;
        salu_rd_en = 1; salu_rd_wfid = 6'd2;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        lsu_rd_wfid = '0;
        repeat (3) @(negedge clk);
        chk("lit_rst_zero", exec_zero, {NW{1'b1}});
        chk("lit_rst_conf", wr_conflict_err, 1'b0);
        rst = 1'b0;

        // Init slot 2, LSU reads it
        @(negedge clk);
        fetch_init_wf_en = 1; fetch_init_wf_id = 6'd2; fetch_init_value = 64'h2D;
        lsu_rd_wfid = 6'd2;
        settle();
        chk("lit_lsu_exec", lsu_exec_value, 64'h2D);
        chk("lit_model_lsu", e_l_exec, 64'h2D);
        chk("lit_zero2", exec_zero[2], 1'b0);
        chk("lit_zero3", exec_zero[3], 1'b1);

        // SALU writes all four fields
        @(negedge clk);
        idle();
        salu_wr_exec_en = 1; salu_wr_vcc_en = 1; salu_wr_m0_en = 1; salu_wr_scc_en = 1;
        salu_wr_wfid = 6'd2; salu_wr_exec_value = 64'h09; salu_wr_vcc_value = 64'h1B;
        salu_wr_m0_value = 32'h0D; salu_wr_scc_value = 1;
        settle();
        chk("lit_iss_all", {issue_salu_wr_exec_en, issue_salu_wr_vcc_en,
                            issue_salu_wr_m0_en, issue_salu_wr_scc_en}, 4'hF);
        chk("lit_iss_wfid", issue_salu_wr_vcc_wfid, 6'd2);
        @(negedge clk);
        idle();
        salu_rd_en = 1; salu_rd_wfid = 6'd2;
        settle();
        chk("lit_rd_exec", salu_rd_exec_value, 64'h09);
        chk("lit_rd_vcc",  salu_rd_vcc_value,  64'h1B);
        chk("lit_rd_scc",  salu_rd_scc_value,  1'b1);
        chk("lit_rd_m0",   salu_rd_m0_value,   32'h0D);
        chk("lit_iss_off", issue_salu_wr_exec_en, 1'b0);
        chk("lit_model_m0", e_s_m0, 32'h0D);

        // Exec RMW modes
        @(negedge clk);
        idle();
        fetch_init_wf_en = 1; fetch_init_wf_id = 6'd2; fetch_init_value = 64'h2D;
        settle();
        salu_exec(2'b01, 64'h0F);
        chk("lit_and", salu_rd_exec_value, 64'h0D);
        salu_exec(2'b10, 64'h30);
        chk("lit_or", salu_rd_exec_value, 64'h3D);
        salu_exec(2'b11, 64'h3D);
        chk("lit_andn2", salu_rd_exec_value, 64'h00);
        chk("lit_zero2_set", exec_zero[2], 1'b1);

        // Granted VALU VCC write, lowest-index VALU read
        @(negedge clk);
        idle();
        valu_vcc_wr_en = 8'h02; rfa_select_fu = 8'h02;
        valu_vcc_wr_wfid[1*WW +: WW] = 6'd2; valu_vcc_value[1*LN +: LN] = 64'h05;
        valu_rd_en = 8'h0A; valu_rd_wfid[1*WW +: WW] = 6'd2; valu_rd_wfid[3*WW +: WW] = 6'd5;
        settle();
        chk("lit_valu_vcc", valu_rd_vcc_value, 64'h05);
        chk("lit_iv_en", issue_valu_wr_vcc_en, 1'b1);
        chk("lit_iv_wfid", issue_valu_wr_vcc_wfid, 6'd2);
        // Ungranted: dropped
        @(negedge clk);
        rfa_select_fu = 8'h04; valu_vcc_value[1*LN +: LN] = 64'h77;
        settle();
        chk("lit_valu_drop", valu_rd_vcc_value, 64'h05);
        chk("lit_iv_off", issue_valu_wr_vcc_en, 1'b0);

        // SALU vs VALU VCC conflict on slot 2, read bypass
        @(negedge clk);
        idle();
        salu_wr_vcc_en = 1; salu_wr_wfid = 6'd2; salu_wr_vcc_value = 64'hAA;
        valu_vcc_wr_en = 8'h02; rfa_select_fu = 8'h02;
        valu_vcc_wr_wfid[1*WW +: WW] = 6'd2; valu_vcc_value[1*LN +: LN] = 64'h55;
        salu_rd_en = 1; salu_rd_wfid = 6'd2;
        settle();
        chk("lit_conf_vcc", salu_rd_vcc_value, 64'hAA);
        chk("lit_conf_set", wr_conflict_err, 1'b1);
        @(negedge clk);
        idle();
        repeat (2) settle();
        chk("lit_conf_sticky", wr_conflict_err, 1'b1);

        // Out-of-range wfid 45
        @(negedge clk);
        idle();
        salu_wr_exec_en = 1; salu_wr_wfid = 6'd45; salu_wr_exec_value = 64'hFF;
        fetch_init_wf_en = 1; fetch_init_wf_id = 6'd45; fetch_init_value = 64'h1;
        salu_rd_en = 1; salu_rd_wfid = 6'd45;
        lsu_rd_wfid = 6'd45;
        settle();
        chk("lit_oor_rd", salu_rd_exec_value, 64'h0);
        chk("lit_oor_iss", issue_salu_wr_exec_en, 1'b0);
        chk("lit_oor_lsu", lsu_exec_value, 64'h0);

        // Reset mid-traffic
        @(negedge clk);
        idle();
        salu_wr_scc_en = 1; salu_wr_wfid = 6'd7; salu_wr_scc_value = 1;
        salu_rd_en = 1; salu_rd_wfid = 6'd2; lsu_rd_wfid = 6'd2;
        settle();
        #1;
        rst = 1'b1;
        #1;
        chk("lit_arst_zero", exec_zero, {NW{1'b1}});
        chk("lit_arst_conf", wr_conflict_err, 1'b0);
        chk("lit_arst_scc_iss", issue_salu_wr_scc_en, 1'b0);
        chk("lit_arst_vcc", salu_rd_vcc_value, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        salu_rd_en = 1; salu_rd_wfid = 6'd2;
        settle();
        chk("lit_post_rst", salu_rd_exec_value, 64'h0);

        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_exec_mask_rf
`default_nettype wire
